// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared types and constants for the rv32i pipeline control.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    typedef enum logic [1:0] {
        DRAIN    = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use comparator between ID sources and EX load.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import rv32i_pkg::*;
(
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic       i_ex_valid,
    input  logic       i_ex_is_load,
    input  logic [4:0] i_ex_rd,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    // x0 is hardwired to zero, so a load targeting it can never be a hazard
    assign o_load_use = i_ex_valid && i_ex_is_load && (i_ex_rd != REG_ZERO)
                        && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_controller
// Description : Stall/flush sequencer for the 5-stage rv32i pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_controller
    import rv32i_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t      r_state;
    logic [DW-1:0]    r_drain_cnt;
    logic [WW-1:0]    r_wait_cnt;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;
    logic             r_mem_timeout;

    logic w_load_use;
    logic w_freeze;
    logic w_stall_evt;
    logic w_flush_evt;

    hazard_detect u_hazard_detect (
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .i_ex_valid    (ex_valid),
        .i_ex_is_load  (ex_is_load),
        .i_ex_rd       (ex_rd),
        .o_load_use    (w_load_use)
    );

    // Once waiting, only the ack releases the freeze, even if req drops
    assign w_freeze = (r_state == MEM_WAIT) ? !dmem_ack : (dmem_req && !dmem_ack);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        w_stall_evt = 1'b0;
        w_flush_evt = 1'b0;
        if (rst || (r_state == DRAIN)) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            exmem_flush = 1'b1;
            memwb_en    = 1'b0;
        end else if (w_freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (ex_valid && ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            w_flush_evt = 1'b1;
        end else if (w_load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
            w_stall_evt = 1'b1;
        end else if (!imem_ready) begin
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            w_stall_evt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= DRAIN;
            r_drain_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_stall_count <= '0;
            r_flush_count <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (w_stall_evt) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (w_flush_evt) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
            case (r_state)
                DRAIN: begin
                    if (r_drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                        r_state     <= RUN;
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DW'(1);
                    end
                end
                RUN: begin
                    if (w_freeze) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= WW'(1);
                        if (MEM_TIMEOUT <= 1) begin
                            r_mem_timeout <= 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else begin
                        // Saturate so a long wait cannot wrap back below the limit
                        if (int'(r_wait_cnt) < MEM_TIMEOUT) begin
                            r_wait_cnt <= r_wait_cnt + WW'(1);
                        end
                        if (int'(r_wait_cnt) + 1 >= MEM_TIMEOUT) begin
                            r_mem_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= DRAIN;
                end
            endcase
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
    assign mem_timeout = r_mem_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_controller
// Description : Directed and random checks of pipeline_controller against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_controller;

    localparam int DR = 4;
    localparam int TO = 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load;
    logic          ex_branch_taken, imem_ready, dmem_req, dmem_ack;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic          exmem_en, exmem_flush, memwb_en, mem_timeout;
    logic [CW-1:0] stall_count, flush_count;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    int            m_drain_left = DR;
    bit            m_waiting    = 1'b0;
    int            m_wait       = 0;
    bit            m_timeout    = 1'b0;
    logic [CW-1:0] m_stall      = '0;
    logic [CW-1:0] m_flush      = '0;

    always #5 clk = ~clk;

    pipeline_controller #(
        .DRAIN_CYCLES (DR),
        .MEM_TIMEOUT  (TO),
        .CNT_W        (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_valid        (ex_valid),
        .ex_is_load      (ex_is_load),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .imem_ready      (imem_ready),
        .dmem_req        (dmem_req),
        .dmem_ack        (dmem_ack),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .exmem_flush     (exmem_flush),
        .memwb_en        (memwb_en),
        .stall_count     (stall_count),
        .flush_count     (flush_count),
        .mem_timeout     (mem_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit model_hazard();
        if (!(ex_valid && ex_is_load) || ex_rd == 5'd0) return 1'b0;
        return (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
    endfunction

    function automatic bit model_frozen();
        return m_waiting ? !dmem_ack : (dmem_req && !dmem_ack);
    endfunction

    // Bit order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_en
    task automatic model_eval(output logic [7:0] exp, output bit stall, output bit flush);
        stall = 1'b0;
        flush = 1'b0;
        if (rst || m_drain_left > 0)      exp = 8'b0010_1010;
        else if (model_frozen())          exp = 8'b0000_0000;
        else if (ex_valid && ex_branch_taken) begin
            exp = 8'b1111_1101; flush = 1'b1;
        end else if (model_hazard()) begin
            exp = 8'b0001_1101; stall = 1'b1;
        end else if (!imem_ready) begin
            exp = 8'b0111_0101; stall = 1'b1;
        end else                          exp = 8'b1101_0101;
    endtask

    task automatic cycle(input string tag);
        logic [7:0] exp;
        bit         st, fl, fz;
        #1;
        model_eval(exp, st, fl);
        fz = model_frozen();
        chk({tag, "_ctl"}, 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                                exmem_en, exmem_flush, memwb_en}), 32'(exp));
        chk({tag, "_stall_cnt"}, stall_count, m_stall);
        chk({tag, "_flush_cnt"}, flush_count, m_flush);
        chk({tag, "_timeout"}, 32'(mem_timeout), 32'(m_timeout));
        @(posedge clk);
        if (rst) begin
            m_drain_left = DR; m_waiting = 1'b0; m_wait = 0;
            m_timeout = 1'b0; m_stall = '0; m_flush = '0;
        end else if (m_drain_left > 0) begin
            m_drain_left--;
        end else if (fz) begin
            m_wait    = m_waiting ? m_wait + 1 : 1;
            m_waiting = 1'b1;
            if (m_wait >= TO) m_timeout = 1'b1;
        end else begin
            m_waiting = 1'b0;
            m_wait    = 0;
            m_stall   = m_stall + CW'(st);
            m_flush   = m_flush + CW'(fl);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
        imem_ready = 1'b1; dmem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        cycle("rst0");
        cycle("rst1");
        rst = 1'b0;
        for (int i = 0; i < DR; i++) cycle("drain");
        #1;
        chk("run_first_pc_en", 32'(pc_en), 32'd1);
        chk("run_first_all_en", 32'({ifid_en, idex_en, exmem_en, memwb_en}), 32'hF);
        cycle("run_first");

        // Load-use on rs2, then the same with x0 as destination
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        #1;
        chk("ld_use_ctl", 32'({pc_en, ifid_en, idex_flush}), 32'b001);
        cycle("ld_use");
        chk("ld_use_stall_cnt", stall_count, 32'd1);
        ex_rd = 5'd0; id_rs2 = 5'd0;
        #1;
        chk("ld_x0_pc_en", 32'(pc_en), 32'd1);
        cycle("ld_x0");
        chk("ld_x0_stall_cnt", stall_count, 32'd1);

        // Branch masks a simultaneous load-use
        ex_rd = 5'd5; id_rs2 = 5'd5; ex_branch_taken = 1'b1;
        #1;
        chk("br_ld_ctl", 32'({pc_en, ifid_flush, idex_flush}), 32'b111);
        cycle("br_ld");
        chk("br_ld_flush_cnt", flush_count, 32'd1);
        chk("br_ld_stall_cnt", stall_count, 32'd1);

        // Memory wait of three cycles, then ack
        idle();
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) cycle("mwait");
        dmem_ack = 1'b1;
        #1;
        chk("mack_en", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'h1F);
        cycle("mack");
        idle();
        cycle("mafter");
        chk("mafter_pc_en", 32'(pc_en), 32'd1);

        // Timeout: flag appears once TO waiting cycles have elapsed and is sticky
        dmem_req = 1'b1;
        for (int i = 0; i < TO - 1; i++) cycle("tmo_wait");
        chk("tmo_before", 32'(mem_timeout), 32'd0);
        cycle("tmo_wait");
        chk("tmo_set", 32'(mem_timeout), 32'd1);
        cycle("tmo_wait");
        cycle("tmo_wait");
        dmem_ack = 1'b1;
        cycle("tmo_ack");
        idle();
        cycle("tmo_after");
        chk("tmo_sticky", 32'(mem_timeout), 32'd1);

        // Fetch wait two cycles
        imem_ready = 1'b0;
        #1;
        chk("fetch_ctl", 32'({pc_en, ifid_flush}), 32'b01);
        cycle("fetch");
        cycle("fetch");
        chk("fetch_stall_cnt", stall_count, 32'd3);
        idle();

        // Randomized traffic with rare resets
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(199) == 0);
            id_rs1          = 5'($urandom_range(3));
            id_rs2          = 5'($urandom_range(3));
            ex_rd           = 5'($urandom_range(3));
            id_uses_rs1     = 1'($urandom_range(1));
            id_uses_rs2     = 1'($urandom_range(1));
            ex_valid        = ($urandom_range(3) != 0);
            ex_is_load      = 1'($urandom_range(1));
            ex_branch_taken = ($urandom_range(4) == 0);
            imem_ready      = ($urandom_range(4) != 0);
            dmem_req        = ($urandom_range(3) == 0);
            dmem_ack        = ($urandom_range(2) == 0);
            cycle("rand");
        end

        idle();
        rst = 1'b1;
        cycle("final_rst");
        chk("tmo_cleared", 32'(mem_timeout), 32'd0);
        chk("stall_cleared", stall_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
